dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths and the
// transaction FSM encoding.
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that was not granted
// last wins; the pointer only moves when the grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  // last_one = 1 means requester 1 won most recently, so requester 0 wins the next tie
  logic last_one;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_one ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_one <= 1'b1;
    end else if (take && (grant != 2'b00)) begin
      last_one <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory. One transaction is
// outstanding at a time: IDLE (grant) -> ACCESS (strobes) -> RESP (hold response).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 65,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  input  logic              p0_resp_ready,
  output logic [DATA_W-1:0] p0_resp_rdata,
  output logic              p0_resp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  input  logic              p1_resp_ready,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              p1_resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  // Handshakes: a request transfers in a cycle where req_valid && req_ready
  // (ready only ever rises in IDLE); a response transfers where
  // resp_valid && resp_ready, and resp data/err hold steady until then.

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               owner;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [1:0]         req_vec;
  logic [1:0]         grant;
  logic               take;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               in_range;
  logic               resp_ready_sel;

  assign req_vec        = {p1_req_valid, p0_req_valid};
  assign take           = (state == ST_IDLE) && (req_vec != 2'b00);
  assign sel_write      = grant[1] ? p1_req_write : p0_req_write;
  assign sel_addr       = grant[1] ? p1_req_addr  : p0_req_addr;
  assign sel_wdata      = grant[1] ? p1_req_wdata : p0_req_wdata;
  assign in_range       = sel_addr < ADDR_W'(MEM_WORDS);
  assign resp_ready_sel = owner ? p1_resp_ready : p0_resp_ready;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .take  (take),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take) state_nxt = in_range ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready_sel) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Out-of-range grants skip ACCESS entirely, so the error response is preloaded here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      owner   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take) begin
        owner   <= grant[1];
        wr_q    <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        cnt     <= CNT_W'(MEM_LATENCY - 1);
        rdata_q <= '0;
        err_q   <= !in_range;
      end else if (state == ST_ACCESS) begin
        if (cnt == '0) begin
          rdata_q <= wr_q ? '0 : mem_rdata;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    p0_resp_rdata = '0;
    p1_resp_rdata = '0;
    p0_resp_err   = 1'b0;
    p1_resp_err   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    busy          = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        p0_req_ready = take && grant[0];
        p1_req_ready = take && grant[1];
      end
      ST_ACCESS: begin
        mem_read  = !wr_q;
        mem_write = wr_q;
      end
      ST_RESP: begin
        if (owner) begin
          p1_resp_valid = 1'b1;
          p1_resp_rdata = rdata_q;
          p1_resp_err   = err_q;
        end else begin
          p0_resp_valid = 1'b1;
          p0_resp_rdata = rdata_q;
          p0_resp_err   = err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-timeline model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_dmem_arbiter;

  localparam int LAT   = 2;
  localparam int WORDS = 65;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_resp_valid, p0_resp_ready, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_resp_valid, p1_resp_ready, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_total = 0;
  int wr_total = 0;
  int dut_grant_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.MEM_WORDS(WORDS), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Environment memory: word i starts at i+3 (so word 4 holds 7)
  logic [31:0] tb_mem [0:WORDS-1];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < WORDS; i++) tb_mem[i] <= 32'(i + 3);
      mem_loaded <= 1'b1;
    end else if (mem_write && mem_addr < 32'(WORDS)) begin
      tb_mem[mem_addr[6:0]] <= mem_wdata;
    end
  end
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_read && mem_addr < 32'(WORDS)) mem_rdata = tb_mem[mem_addr[6:0]];
  end

  always @(negedge clk) begin
    if (mem_read) rd_total <= rd_total + 1;
    if (mem_write) wr_total <= wr_total + 1;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [0:WORDS-1];
  logic        ref_loaded = 1'b0;
  logic        m_active, m_last, m_owner, m_write, m_err, mwin;
  logic [1:0]  mv;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_t, age, lat;

  always @(negedge clk) begin
    if (!ref_loaded) begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'(i + 3);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready0", p0_req_ready, 0);
      chk("rst_ready1", p1_req_ready, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_resp_valid0", p0_resp_valid, 0);
      chk("rst_resp_valid1", p1_resp_valid, 0);
      chk("rst_rdata0", p0_resp_rdata, 0);
      chk("rst_rdata1", p1_resp_rdata, 0);
      m_active = 1'b0;
      m_last   = 1'b1;
    end else if (!m_active) begin
      mv = {p1_req_valid, p0_req_valid};
      mwin = (mv == 2'b11) ? !m_last : mv[1];
      chk("idle_ready0", p0_req_ready, 32'(mv != 2'b00 && mwin == 1'b0));
      chk("idle_ready1", p1_req_ready, 32'(mv != 2'b00 && mwin == 1'b1));
      chk("idle_busy", busy, 0);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_resp_valid0", p0_resp_valid, 0);
      chk("idle_resp_valid1", p1_resp_valid, 0);
      if (mv != 2'b00) begin
        m_active = 1'b1;
        m_t      = cyc;
        m_owner  = mwin;
        m_last   = mwin;
        m_write  = mwin ? p1_req_write : p0_req_write;
        m_addr   = mwin ? p1_req_addr : p0_req_addr;
        m_wdata  = mwin ? p1_req_wdata : p0_req_wdata;
        m_err    = (m_addr >= 32'(WORDS));
        m_rdata  = (m_write || m_err) ? 32'h0 : ref_mem[m_addr[6:0]];
        if (m_write && !m_err) ref_mem[m_addr[6:0]] = m_wdata;
      end
    end else begin
      age = cyc - m_t;
      lat = m_err ? 0 : LAT;
      chk("busy", busy, 1);
      chk("ready0_while_busy", p0_req_ready, 0);
      chk("ready1_while_busy", p1_req_ready, 0);
      if (age <= lat) begin
        chk("access_mem_read", mem_read, 32'(!m_write));
        chk("access_mem_write", mem_write, 32'(m_write));
        chk("access_mem_addr", mem_addr, m_addr);
        chk("access_mem_wdata", mem_wdata, m_wdata);
        chk("access_resp_valid0", p0_resp_valid, 0);
        chk("access_resp_valid1", p1_resp_valid, 0);
      end else begin
        chk("resp_mem_read", mem_read, 0);
        chk("resp_mem_write", mem_write, 0);
        chk("resp_valid0", p0_resp_valid, 32'(m_owner == 1'b0));
        chk("resp_valid1", p1_resp_valid, 32'(m_owner == 1'b1));
        chk("resp_rdata", m_owner ? p1_resp_rdata : p0_resp_rdata, m_rdata);
        chk("resp_err", m_owner ? p1_resp_err : p0_resp_err, 32'(m_err));
        if (m_owner ? p1_resp_ready : p0_resp_ready) m_active = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1; drives the request immediately.
  task automatic txn(input int port, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err,
                     output int t_acc, output int t_resp, output int t_done);
    bit ok;
    rdata = 32'h0; err = 1'b0; t_acc = -1; t_resp = -1; t_done = -1;
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = addr; p1_req_wdata = wdata;
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_req_ready : p1_req_ready) begin ok = 1'b1; t_acc = cyc; end
    end
    @(posedge clk); #1;
    if (port == 0) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: port %0d got no ready within 200 cycles", port);
      return;
    end
    dut_grant_q.push_back(port);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_resp_valid : p1_resp_valid) begin
        ok = 1'b1; t_resp = cyc;
        rdata = (port == 0) ? p0_resp_rdata : p1_resp_rdata;
        err   = (port == 0) ? p0_resp_err : p1_resp_err;
      end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL resp_timeout: port %0d got no resp_valid within 50 cycles", port);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", (port == 0) ? p0_resp_valid : p1_resp_valid, 1);
      chk("hold_rdata", (port == 0) ? p0_resp_rdata : p1_resp_rdata, rdata);
      chk("hold_err", (port == 0) ? p0_resp_err : p1_resp_err, 32'(err));
    end
    @(posedge clk); #1;
    if (port == 0) p0_resp_ready = 1'b1; else p1_resp_ready = 1'b1;
    @(negedge clk);
    t_done = cyc;
    @(posedge clk); #1;
    if (port == 0) p0_resp_ready = 1'b0; else p1_resp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] r;
  logic        e;
  int          ta, tr, td, rd0, wr0;
  int          exp_grants [8];
  logic [31:0] r1;
  logic        e1;
  int          ta1, tr1, td1;

  initial begin
    rst_n = 1'b0;
    p0_req_valid = 0; p0_req_write = 0; p0_req_addr = 0; p0_req_wdata = 0; p0_resp_ready = 0;
    p1_req_valid = 0; p1_req_write = 0; p1_req_addr = 0; p1_req_wdata = 0; p1_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // read word 4 (preloaded 7) from p0
    rd0 = rd_total; wr0 = wr_total;
    txn(0, 1'b0, 32'd4, 32'h0, 0, r, e, ta, tr, td);
    chk("read4_rdata", r, 32'd7);
    chk("read4_err", 32'(e), 0);
    chk("read4_latency", 32'(tr - ta), 3);
    chk("read4_strobe_cycles", 32'(rd_total - rd0), 2);
    chk("read4_no_write", 32'(wr_total - wr0), 0);

    // p1 write then read back word 10
    rd0 = rd_total; wr0 = wr_total;
    txn(1, 1'b1, 32'd10, 32'h0000DEAD, 0, r, e, ta, tr, td);
    chk("write10_rdata", r, 0);
    chk("write10_err", 32'(e), 0);
    chk("write10_strobe_cycles", 32'(wr_total - wr0), 2);
    chk("write10_no_read", 32'(rd_total - rd0), 0);
    rd0 = rd_total; wr0 = wr_total;
    txn(1, 1'b0, 32'd10, 32'h0, 0, r, e, ta, tr, td);
    chk("read10_rdata", r, 32'h0000DEAD);
    chk("read10_no_write", 32'(wr_total - wr0), 0);
    chk("read10_strobe_cycles", 32'(rd_total - rd0), 2);

    // address boundary: 64 is the last word, 65 is out of range
    txn(1, 1'b1, 32'd64, 32'h00001234, 0, r, e, ta, tr, td);
    chk("write64_err", 32'(e), 0);
    txn(0, 1'b0, 32'd64, 32'h0, 0, r, e, ta, tr, td);
    chk("read64_rdata", r, 32'h00001234);
    rd0 = rd_total; wr0 = wr_total;
    txn(1, 1'b1, 32'd65, 32'h00005555, 0, r, e, ta, tr, td);
    chk("write65_err", 32'(e), 1);
    chk("write65_no_strobe", 32'(rd_total - rd0 + wr_total - wr0), 0);

    // out-of-range read
    rd0 = rd_total; wr0 = wr_total;
    txn(0, 1'b0, 32'd70, 32'h0, 0, r, e, ta, tr, td);
    chk("read70_err", 32'(e), 1);
    chk("read70_rdata", r, 0);
    chk("read70_latency", 32'(tr - ta), 1);
    chk("read70_no_strobe", 32'(rd_total - rd0 + wr_total - wr0), 0);

    // contention from reset: grants must alternate starting with p0
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dut_grant_q.delete();
    fork
      begin : rr_p0
        logic [31:0] rr_r; logic rr_e; int a0, b0, c0;
        for (int i = 0; i < 4; i++) begin
          txn(0, 1'b0, 32'(i * 2), 32'h0, 0, rr_r, rr_e, a0, b0, c0);
          chk("rr_p0_rdata", rr_r, 32'(i * 2 + 3));
        end
      end
      begin : rr_p1
        logic [31:0] rr_r; logic rr_e; int a1, b1, c1;
        for (int i = 0; i < 4; i++) begin
          txn(1, 1'b1, 32'(20 + i), 32'(32'h100 + i), 0, rr_r, rr_e, a1, b1, c1);
          chk("rr_p1_rdata", rr_r, 0);
        end
      end
    join
    exp_grants = '{0, 1, 0, 1, 0, 1, 0, 1};
    chk("rr_grant_count", 32'(dut_grant_q.size()), 8);
    for (int i = 0; i < 8 && i < dut_grant_q.size(); i++)
      chk("rr_grant_order", 32'(dut_grant_q[i]), 32'(exp_grants[i]));

    // p0 stalls its response 3 cycles while p1 waits
    fork
      txn(0, 1'b0, 32'd4, 32'h0, 3, r, e, ta, tr, td);
      begin
        repeat (2) @(posedge clk);
        #1;
        txn(1, 1'b0, 32'd21, 32'h0, 0, r1, e1, ta1, tr1, td1);
      end
    join
    chk("stall_p0_rdata", r, 32'd7);
    chk("stall_p1_accept_after_handshake", 32'(ta1 - td), 1);
    chk("stall_p1_rdata", r1, 32'h101);

    // reset in the middle of ACCESS
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 32'd5;
    ta = -1;
    for (int i = 0; i < 20 && ta < 0; i++) begin
      @(negedge clk);
      if (p0_req_ready) ta = cyc;
    end
    chk("midreset_accepted", 32'(ta >= 0), 1);
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    chk("midreset_in_access", mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_mem_read", mem_read, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_mem_write", mem_write, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_resp", p0_resp_valid, 0);
    end
    @(posedge clk); #1;
    txn(0, 1'b0, 32'd4, 32'h0, 0, r, e, ta, tr, td);
    chk("after_reset_rdata", r, 32'd7);
    chk("after_reset_latency", 32'(tr - ta), 3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
